// File: rtl/cpu_stat_counter.sv
// Run/halt control and retirement statistics for a single-cycle CPU.
// Counters advance only while running; a synchronized go edge resumes from halt.
module cpu_stat_counter #(
  parameter int CNT_W    = 16,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             is_jump,
  input  logic             is_branch,
  input  logic             branch_taken,
  input  logic             halt,
  input  logic             go,
  input  logic             clear,
  output logic             cpu_en,
  output logic             halted,
  output logic [CNT_W-1:0] all_time,
  output logic [CNT_W-1:0] j_change,
  output logic [CNT_W-1:0] b_change,
  output logic [CNT_W-1:0] b_change_success
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [0:0]       state_q, state_d;
  logic             sync1_q, sync2_q, sync3_q;
  logic             go_rise_q, go_rise_d;
  logic             run;
  logic [CNT_W-1:0] all_q, all_d;
  logic [CNT_W-1:0] jmp_q, jmp_d;
  logic [CNT_W-1:0] br_q, br_d;
  logic [CNT_W-1:0] brt_q, brt_d;

  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v);
    if (&v) return SATURATE ? v : '0;
    return v + CNT_ONE;
  endfunction

  assign run = (state_q == ST_RUN);

  // Registering the qualified edge gives go sampled at edge 1 -> cpu_en high after edge 4;
  // edges seen while running are dropped rather than remembered.
  always_comb begin
    go_rise_d = sync2_q & ~sync3_q & (state_q == ST_HALT);
    state_d   = state_q;
    if (state_q == ST_RUN) begin
      if (halt) state_d = ST_HALT;
    end else begin
      if (go_rise_q) state_d = ST_RUN;
    end
  end

  always_comb begin
    all_d = all_q;
    jmp_d = jmp_q;
    br_d  = br_q;
    brt_d = brt_q;
    if (clear) begin
      all_d = '0;
      jmp_d = '0;
      br_d  = '0;
      brt_d = '0;
    end else if (run) begin
      all_d = bump(all_q);
      if (is_jump)                  jmp_d = bump(jmp_q);
      if (is_branch)                br_d  = bump(br_q);
      if (is_branch & branch_taken) brt_d = bump(brt_q);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_RUN;
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      sync3_q   <= 1'b0;
      go_rise_q <= 1'b0;
      all_q     <= '0;
      jmp_q     <= '0;
      br_q      <= '0;
      brt_q     <= '0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= go;
      sync2_q   <= sync1_q;
      sync3_q   <= sync2_q;
      go_rise_q <= go_rise_d;
      all_q     <= all_d;
      jmp_q     <= jmp_d;
      br_q      <= br_d;
      brt_q     <= brt_d;
    end
  end

  assign cpu_en           = (state_q == ST_RUN);
  assign halted           = (state_q == ST_HALT);
  assign all_time         = all_q;
  assign j_change         = jmp_q;
  assign b_change         = br_q;
  assign b_change_success = brt_q;

endmodule

// File: tb/tb_cpu_stat_counter.sv
// Directed plus random bench for cpu_stat_counter: one 16-bit saturating instance and
// two 4-bit instances (saturating and wrapping) driven from the same inputs.
module tb_cpu_stat_counter;

  logic clk = 1'b0;
  logic reset;
  logic is_jump, is_branch, branch_taken, halt, go, clear;

  logic        en16, hlt16, en_s, hlt_s, en_w, hlt_w;
  logic [15:0] at16, jc16, bc16, bs16;
  logic [3:0]  at_s, jc_s, bc_s, bs_s;
  logic [3:0]  at_w, jc_w, bc_w, bs_w;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: one run/halt flag, go sample history, counters per instance.
  bit          m_halted;
  bit          m_halted_prev;
  bit          p1, p2, p3, p4;
  int unsigned mc[3][4];
  int          inst_w[3]   = '{16, 4, 4};
  bit          inst_sat[3] = '{1'b1, 1'b1, 1'b0};

  always #5 clk = ~clk;

  cpu_stat_counter #(.CNT_W(16), .SATURATE(1'b1)) u_dut (
    .clk(clk), .reset(reset), .is_jump(is_jump), .is_branch(is_branch),
    .branch_taken(branch_taken), .halt(halt), .go(go), .clear(clear),
    .cpu_en(en16), .halted(hlt16), .all_time(at16), .j_change(jc16),
    .b_change(bc16), .b_change_success(bs16));

  cpu_stat_counter #(.CNT_W(4), .SATURATE(1'b1)) u_sat (
    .clk(clk), .reset(reset), .is_jump(is_jump), .is_branch(is_branch),
    .branch_taken(branch_taken), .halt(halt), .go(go), .clear(clear),
    .cpu_en(en_s), .halted(hlt_s), .all_time(at_s), .j_change(jc_s),
    .b_change(bc_s), .b_change_success(bs_s));

  cpu_stat_counter #(.CNT_W(4), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .reset(reset), .is_jump(is_jump), .is_branch(is_branch),
    .branch_taken(branch_taken), .halt(halt), .go(go), .clear(clear),
    .cpu_en(en_w), .halted(hlt_w), .all_time(at_w), .j_change(jc_w),
    .b_change(bc_w), .b_change_success(bs_w));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int unsigned bump(input int unsigned v, input int w, input bit sat);
    int unsigned max_v;
    max_v = (32'd1 << w) - 1;
    if (v == max_v) return sat ? max_v : 0;
    return v + 1;
  endfunction

  task automatic model_reset();
    m_halted      = 1'b0;
    m_halted_prev = 1'b0;
    {p1, p2, p3, p4} = 4'b0;
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < 4; k++) mc[i][k] = 0;
  endtask

  // One rising edge: counters follow the state held during the cycle; a halted CPU
  // resumes when go was first seen high three edges earlier while already halted.
  task automatic model_edge(input bit j, input bit b, input bit t, input bit h,
                            input bit g, input bit c);
    bit run, resume, nh;
    run = !m_halted;
    for (int i = 0; i < 3; i++) begin
      if (c) begin
        for (int k = 0; k < 4; k++) mc[i][k] = 0;
      end else if (run) begin
        mc[i][0] = bump(mc[i][0], inst_w[i], inst_sat[i]);
        if (j)     mc[i][1] = bump(mc[i][1], inst_w[i], inst_sat[i]);
        if (b)     mc[i][2] = bump(mc[i][2], inst_w[i], inst_sat[i]);
        if (b & t) mc[i][3] = bump(mc[i][3], inst_w[i], inst_sat[i]);
      end
    end
    resume = m_halted && m_halted_prev && p3 && !p4;
    nh = run ? h : !resume;
    p4 = p3; p3 = p2; p2 = p1; p1 = g;
    m_halted_prev = m_halted;
    m_halted      = nh;
  endtask

  task automatic check_all();
    check("cpu_en",    en16,  !m_halted);
    check("halted",    hlt16, m_halted);
    check("halted_s4", hlt_s, m_halted);
    check("halted_w4", hlt_w, m_halted);
    check("all_time",  at16, mc[0][0]);
    check("j_change",  jc16, mc[0][1]);
    check("b_change",  bc16, mc[0][2]);
    check("b_succ",    bs16, mc[0][3]);
    check("all_time_s4", at_s, mc[1][0]);
    check("j_change_s4", jc_s, mc[1][1]);
    check("b_change_s4", bc_s, mc[1][2]);
    check("b_succ_s4",   bs_s, mc[1][3]);
    check("all_time_w4", at_w, mc[2][0]);
    check("j_change_w4", jc_w, mc[2][1]);
    check("b_change_w4", bc_w, mc[2][2]);
    check("b_succ_w4",   bs_w, mc[2][3]);
  endtask

  task automatic step(input bit j, input bit b, input bit t, input bit h,
                      input bit g, input bit c);
    @(negedge clk);
    is_jump = j; is_branch = b; branch_taken = t; halt = h; go = g; clear = c;
    @(posedge clk);
    model_edge(j, b, t, h, g, c);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cpu_en"}, en16, 1'b1);
    check({tag, "_halted"}, hlt16, 1'b0);
    check({tag, "_all"},    at16, 0);
    check({tag, "_jmp"},    jc16, 0);
    check({tag, "_br"},     bc16, 0);
    check({tag, "_brt"},    bs16, 0);
    check({tag, "_all_s4"}, at_s, 0);
    check({tag, "_all_w4"}, at_w, 0);
  endtask

  initial begin
    bit rg;
    reset = 1'b0;
    {is_jump, is_branch, branch_taken, halt, go, clear} = 6'b0;
    model_reset();
    #3;
    check_reset_outputs("reset");
    @(posedge clk); #2 reset = 1'b1;

    // Idle run: only all_time moves.
    idle(10);
    check("idle10_all_time", at16, 10);
    check("idle10_jmp",      jc16, 0);
    check("idle10_cpu_en",   en16, 1'b1);

    // jump, taken branch, untaken branch, then halt (halting cycle counted).
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    check("pat_halted",   hlt16, 1'b1);
    check("pat_all_time", at16, 14);
    check("pat_jmp",      jc16, 1);
    check("pat_br",       bc16, 2);
    check("pat_brt",      bs16, 1);
    idle(20);
    check("halt_hold_all_time", at16, 14);

    // go held high: one resume on the fourth edge, halt again while still held.
    for (int i = 0; i < 50; i++) begin
      step(0, 0, 0, (i == 20), 1, 0);
      if (i == 2) check("resume_not_yet", en16, 1'b0);
      if (i == 3) check("resume_edge4", en16, 1'b1);
    end
    check("held_go_single_resume", hlt16, 1'b1);

    // Short go pulse resumes.
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    idle(3);
    check("pulse_resume", en16, 1'b1);

    // Clear beats a simultaneous branch; the next branch counts from zero.
    step(0, 1, 1, 0, 0, 1);
    check("clear_prio_br", bc16, 0);
    step(0, 1, 0, 0, 0, 0);
    check("br_after_clear", bc16, 1);

    // 4-bit instances after 20 counted cycles: saturate at 15, wrap to 4.
    step(0, 0, 0, 0, 0, 1);
    idle(20);
    check("sat4_all_time",  at_s, 15);
    check("wrap4_all_time", at_w, 4);

    // Random traffic, including illegal jump+branch and go toggling in both states.
    rg = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) rg = ~rg;
      step($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 11) == 0, rg, $urandom_range(0, 49) == 0);
    end

    // Reset pulsed between edges while halted with a go edge in flight.
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    idle(3);
    check("pre_reset_halted", hlt16, m_halted);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    #1 reset = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    go = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk); #2 reset = 1'b1;
    step(0, 0, 0, 1, 0, 0);
    idle(8);
    check("no_resume_after_reset", hlt16, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
